booth_mul16_seq: RTL and testbench

Sequential 16×16 multiplier that reuses one add/subtract datapath over 17 cycles with radix-2 Booth recoding. It gives the ALU a multiply operation without a full array multiplier. It supports signed and unsigned operands through the same `sign` convention as the 16-bit adder, and returns a 32-bit product through a start/busy/done handshake.

---
 rtl/mul_if.sv | 23 ++
 rtl/booth_mul16_seq.sv | 135 +++++++++++++
 tb/tb_booth_mul16_seq.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mul_if.sv
// Start/busy/done handshake bundle for the sequential multiplier.
// The master drives operands and start; the slave returns status and product.
interface mul_if #(
    parameter int WIDTH = 16
);
    logic                 start;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 sign;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, A, B, sign,
        input  busy, done, product
    );

    modport slave (
        input  start, A, B, sign,
        output busy, done, product
    );
endinterface

// File: rtl/booth_mul16_seq.sv
// Radix-2 Booth sequential multiplier: one shared add/subtract datapath,
// WIDTH+1 iterations per product, signed or unsigned operands.
module booth_mul16_seq #(
    parameter int WIDTH = 16
) (
    input  logic   clk,
    input  logic   rst,
    mul_if.slave   bus
);
    localparam int          HW   = WIDTH + 2;
    localparam int          LW   = WIDTH + 1;
    localparam logic [4:0]  LAST = 5'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic                 accept_s;
    logic                 iterate_s;
    logic                 finish_s;

    logic [HW-1:0]        h_r;
    logic [HW-1:0]        m_r;
    logic [LW-1:0]        l_r;
    logic                 q_r;
    logic [4:0]           cnt_r;
    logic                 busy_r;
    logic                 done_r;
    logic [2*WIDTH-1:0]   product_r;

    logic [HW-1:0]        a_ext_s;
    logic [LW-1:0]        b_ext_s;
    logic                 op_s;
    logic                 sub_s;
    logic [HW-1:0]        addend_s;
    logic [HW-1:0]        sum_s;
    logic [HW-1:0]        h_acc_s;
    logic [HW-1:0]        h_sh_s;
    logic [LW-1:0]        l_sh_s;
    logic [HW+LW-1:0]     prod_full_s;

    // Next-state and sequencing controls.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        iterate_s    = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.start) begin
                    accept_s     = 1'b1;
                    state_next_s = S_RUN;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_RUN: begin
                iterate_s = 1'b1;
                if (cnt_r == LAST) begin
                    finish_s     = 1'b1;
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    accept_s     = 1'b1;
                    state_next_s = S_RUN;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Booth step: the single adder subtracts as H + ~M + 1.
    always_comb begin
        a_ext_s     = {{2{bus.sign & bus.A[WIDTH-1]}}, bus.A};
        b_ext_s     = {bus.sign & bus.B[WIDTH-1], bus.B};
        op_s        = l_r[0] ^ q_r;
        sub_s       = l_r[0] & ~q_r;
        addend_s    = sub_s ? ~m_r : m_r;
        sum_s       = h_r + addend_s + {{(HW-1){1'b0}}, sub_s};
        h_acc_s     = op_s ? sum_s : h_r;
        h_sh_s      = {h_acc_s[HW-1], h_acc_s[HW-1:1]};
        l_sh_s      = {h_acc_s[0], l_r[LW-1:1]};
        prod_full_s = {h_sh_s, l_sh_s};
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            h_r       <= '0;
            m_r       <= '0;
            l_r       <= '0;
            q_r       <= 1'b0;
            cnt_r     <= 5'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= '0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == S_RUN);
            done_r  <= finish_s;
            if (accept_s) begin
                m_r   <= a_ext_s;
                l_r   <= b_ext_s;
                h_r   <= '0;
                q_r   <= 1'b0;
                cnt_r <= 5'd0;
            end else if (iterate_s) begin
                h_r   <= h_sh_s;
                l_r   <= l_sh_s;
                q_r   <= l_r[0];
                cnt_r <= cnt_r + 5'd1;
            end
            if (finish_s) begin
                product_r <= prod_full_s[2*WIDTH-1:0];
            end
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;
endmodule

// File: tb/tb_booth_mul16_seq.sv
// Directed bench for booth_mul16_seq: hand-computed products, handshake
// timing, ignored start, back-to-back issue and mid-operation reset.
module tb_booth_mul16_seq;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    mul_if #(.WIDTH(16)) bus ();

    booth_mul16_seq #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic s);
        bus.A     = a;
        bus.B     = b;
        bus.sign  = s;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.A     = 16'hDEAD;
        bus.B     = 16'hBEEF;
        bus.sign  = ~s;
    endtask

    // Advance until done (bounded); cyc = -1 on timeout, ok = busy held until done.
    task automatic wait_done(output int cyc, output logic ok);
        cyc = 0;
        ok  = 1'b1;
        while (cyc < 40 && bus.done !== 1'b1) begin
            if (bus.busy !== 1'b1) ok = 1'b0;
            tick();
            cyc++;
        end
        if (bus.done !== 1'b1) cyc = -1;
        else if (bus.busy !== 1'b0) ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b product=%h required 0 0 00000000",
                     bus.busy, bus.done, bus.product);
        end
    endtask

    task automatic test_basic_unsigned();
        int   cyc;
        logic ok;
        launch(16'h0003, 16'h0005, 1'b0);
        wait_done(cyc, ok);
        n_cmp++;
        if (cyc !== 17) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d cycles required 17", cyc);
        end
        n_cmp++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: busy not high E0..E16 or high with done");
        end
        n_cmp++;
        if (bus.product !== 32'h0000_000F) begin
            n_fail++;
            $display("FAIL basic_product: got %h required 0000000f", bus.product);
        end
        tick();
        n_cmp++;
        if (bus.done !== 1'b0 || bus.product !== 32'h0000_000F) begin
            n_fail++;
            $display("FAIL basic_done_pulse: done=%b product=%h required 0 0000000f",
                     bus.done, bus.product);
        end
    endtask

    task automatic test_products();
        logic [15:0] va [5] = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'h8000, 16'h0007};
        logic [15:0] vb [5] = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'h7FFF, 16'hFFFD};
        logic        vs [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [31:0] ve [5] = '{32'hFFFE_0001, 32'h0000_0001, 32'h4000_0000,
                                32'hC000_8000, 32'hFFFF_FFEB};
        int   cyc;
        logic ok;
        for (int i = 0; i < 5; i++) begin
            launch(va[i], vb[i], vs[i]);
            wait_done(cyc, ok);
            n_cmp++;
            if (cyc !== 17 || ok !== 1'b1 || bus.product !== ve[i]) begin
                n_fail++;
                $display("FAIL product_%0d: cycles=%0d busy_ok=%b product=%h required 17 1 %h",
                         i, cyc, ok, bus.product, ve[i]);
            end
        end
        tick();
    endtask

    task automatic test_ignored_start();
        int   cyc;
        int   extra;
        logic ok;
        launch(16'h0123, 16'h0345, 1'b0);
        repeat (4) tick();
        bus.A     = 16'hFFFF;
        bus.B     = 16'hFFFF;
        bus.sign  = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(cyc, ok);
        n_cmp++;
        if (cyc !== 12 || ok !== 1'b1) begin
            n_fail++;
            $display("FAIL ignored_timing: cycles after E5=%0d busy_ok=%b required 12 1", cyc, ok);
        end
        n_cmp++;
        // 0x123 * 0x345 = 291 * 837 = 243567
        if (bus.product !== 32'h0003_B76F) begin
            n_fail++;
            $display("FAIL ignored_product: got %h required 0003b76f", bus.product);
        end
        extra = 0;
        repeat (20) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL ignored_second_op: %0d cycles of done/busy required 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int   cyc;
        logic ok;
        bus.A     = 16'h0002;
        bus.B     = 16'h0003;
        bus.sign  = 1'b0;
        bus.start = 1'b1;
        tick();
        wait_done(cyc, ok);
        bus.A = 16'h0004;
        bus.B = 16'h0005;
        n_cmp++;
        if (cyc !== 17 || ok !== 1'b1 || bus.product !== 32'h0000_0006) begin
            n_fail++;
            $display("FAIL b2b_first: cycles=%0d busy_ok=%b product=%h required 17 1 00000006",
                     cyc, ok, bus.product);
        end
        tick();
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_no_idle: busy=%b done=%b required 1 0", bus.busy, bus.done);
        end
        wait_done(cyc, ok);
        n_cmp++;
        if (cyc !== 17 || ok !== 1'b1 || bus.product !== 32'h0000_0014) begin
            n_fail++;
            $display("FAIL b2b_second: cycles=%0d busy_ok=%b product=%h required 17 1 00000014",
                     cyc, ok, bus.product);
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        int   cyc;
        int   seen;
        logic ok;
        launch(16'h1234, 16'h0010, 1'b0);
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL midreset_state: busy=%b done=%b product=%h required 0 0 00000000",
                     bus.busy, bus.done, bus.product);
        end
        seen = 0;
        repeat (20) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL midreset_quiet: %0d active cycles required 0", seen);
        end
        launch(16'h1234, 16'h0010, 1'b0);
        wait_done(cyc, ok);
        n_cmp++;
        if (cyc !== 17 || ok !== 1'b1 || bus.product !== 32'h0001_2340) begin
            n_fail++;
            $display("FAIL midreset_rerun: cycles=%0d busy_ok=%b product=%h required 17 1 00012340",
                     cyc, ok, bus.product);
        end
        tick();
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = 16'h0000;
        bus.B     = 16'h0000;
        bus.sign  = 1'b0;
        test_reset();
        test_basic_unsigned();
        test_products();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
